// File: rtl/clock_phase_pkg.sv
// ---------------------------------------------------------------------------
// clock_phase_pkg
//
// Shared definitions for the clock_phase_gen slice.
//   - S_IDLE / S_RUN : state encoding of the slow-clock generator FSM
//   - DIV_MIN        : smallest period the generator can produce
//   - clampDiv       : legalises a requested period
//   - clampHigh      : legalises a requested high time against the
//                      legalised period
//
// The clamp helpers work on 32-bit words so that one definition serves
// every counter width up to 32 bits; callers size-cast in and out.
// ---------------------------------------------------------------------------
package clock_phase_pkg;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [31:0] DIV_MIN = 32'd2;

  // A period shorter than two cycles cannot hold both a high and a low
  // phase, so it is raised to the minimum.
  function automatic logic [31:0] clampDiv(input logic [31:0] divReq);
    return (divReq < DIV_MIN) ? DIV_MIN : divReq;
  endfunction

  // The high time must be at least one cycle and leave at least one low
  // cycle inside the (already clamped) period.
  function automatic logic [31:0] clampHigh(input logic [31:0] divReq,
                                            input logic [31:0] highReq);
    logic [31:0] divOk;
    logic [31:0] highOk;
    divOk  = clampDiv(divReq);
    highOk = (highReq == 32'd0) ? 32'd1 : highReq;
    if (highOk >= divOk) begin
      highOk = divOk - 32'd1;
    end
    return highOk;
  endfunction

endpackage

// File: rtl/clock_phase_cfg.sv
// ---------------------------------------------------------------------------
// clock_phase_cfg
//
// Configuration path of clock_phase_gen: captures clamped load requests
// into a shadow register, holds them pending, and transfers them into the
// active period/high-time registers when the FSM signals a safe point.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   cfg_load_i     one-cycle request to capture div_ratio_i/high_cycles_i
//   div_ratio_i    requested period in clk cycles
//   high_cycles_i  requested high cycles per period
//   apply_en_i     FSM says this edge is a legal point to switch config
//   div_act_o      active period
//   high_act_o     active high time
//   cfg_ack_o      one-cycle pulse after the edge that applied a config
// ---------------------------------------------------------------------------
module clock_phase_cfg
  import clock_phase_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int DIV_DEFAULT  = 4,
  parameter int HIGH_DEFAULT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load_i,
  input  logic [CNT_W-1:0] div_ratio_i,
  input  logic [CNT_W-1:0] high_cycles_i,
  input  logic             apply_en_i,
  output logic [CNT_W-1:0] div_act_o,
  output logic [CNT_W-1:0] high_act_o,
  output logic             cfg_ack_o
);

  logic [CNT_W-1:0] shadowDiv_q;
  logic [CNT_W-1:0] shadowHigh_q;
  logic             pending_q;
  logic [CNT_W-1:0] divAct_q;
  logic [CNT_W-1:0] highAct_q;
  logic             ack_q;
  logic             applyNow;

  // Only a pending request can be applied; the shadow value read here is
  // the one captured before this edge, so a load on the apply edge simply
  // becomes the next pending request.
  assign applyNow = pending_q & apply_en_i;

  // Shadow capture, pending bookkeeping and active-register update.
  // A new load always leaves pending set, even on an apply edge, which is
  // what lets a coincident request survive to the following boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadowDiv_q  <= CNT_W'(DIV_DEFAULT);
      shadowHigh_q <= CNT_W'(HIGH_DEFAULT);
      pending_q    <= 1'b0;
      divAct_q     <= CNT_W'(DIV_DEFAULT);
      highAct_q    <= CNT_W'(HIGH_DEFAULT);
      ack_q        <= 1'b0;
    end else begin
      if (cfg_load_i) begin
        shadowDiv_q  <= CNT_W'(clampDiv(32'(div_ratio_i)));
        shadowHigh_q <= CNT_W'(clampHigh(32'(div_ratio_i), 32'(high_cycles_i)));
      end
      if (applyNow) begin
        divAct_q  <= shadowDiv_q;
        highAct_q <= shadowHigh_q;
      end
      pending_q <= cfg_load_i | (pending_q & ~apply_en_i);
      ack_q     <= applyNow;
    end
  end

  assign div_act_o  = divAct_q;
  assign high_act_o = highAct_q;
  assign cfg_ack_o  = ack_q;

endmodule

// File: rtl/clock_phase_gen.sv
// ---------------------------------------------------------------------------
// clock_phase_gen
//
// Registered slow-clock generator with programmable period and high time,
// one-cycle rise/fall strobes and an N-phase step counter. Configuration
// changes take effect only at period wraps (or immediately while idle) and
// are acknowledged with a one-cycle cfg_ack pulse.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   run          1 = generate, 0 = idle
//   stall        (only with CLOCK_PHASE_GEN_STALL_EN) freeze the period
//   cfg_load     one-cycle request to load div_ratio/high_cycles
//   div_ratio    requested period in clk cycles
//   high_cycles  requested high cycles per period
//   cfg_ack      pulse when a new config becomes active
//   clk_slow     registered divided clock
//   slow_rise    strobe in the first high cycle of a period
//   slow_fall    strobe in the first low cycle of a period
//   phase        phase index, advances once per slow period
//
// Optional build macro: CLOCK_PHASE_GEN_STALL_EN adds the stall input.
// Without it the generator behaves as if stall were tied low.
// CNT_W is limited to 32 bits by the shared clamp helpers.
// ---------------------------------------------------------------------------
module clock_phase_gen
  import clock_phase_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int NUM_PHASES   = 4,
  parameter int DIV_DEFAULT  = 4,
  parameter int HIGH_DEFAULT = 2,
  localparam int PH_W        = $clog2(NUM_PHASES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
`ifdef CLOCK_PHASE_GEN_STALL_EN
  input  logic             stall,
`endif
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic [CNT_W-1:0] high_cycles,
  output logic             cfg_ack,
  output logic             clk_slow,
  output logic             slow_rise,
  output logic             slow_fall,
  output logic [PH_W-1:0]  phase
);

  logic [0:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             clkSlow_q, clkSlow_d;
  logic             rise_q,    rise_d;
  logic             fall_q,    fall_d;
  logic [PH_W-1:0]  phase_q,   phase_d;

  logic [CNT_W-1:0] divAct;
  logic [CNT_W-1:0] highAct;
  logic             stallIn;
  logic             wrap;
  logic [CNT_W-1:0] cntNext;
  logic             applyEn;

`ifdef CLOCK_PHASE_GEN_STALL_EN
  assign stallIn = stall;
`else
  assign stallIn = 1'b0;
`endif

  assign wrap    = (cnt_q == divAct - CNT_W'(1));
  assign cntNext = wrap ? '0 : cnt_q + CNT_W'(1);

  // While idle a pending config can go live at once; while running it
  // waits for the period wrap, and a stalled wrap does not count.
  assign applyEn = (state_q == S_IDLE) | (wrap & ~stallIn);

  clock_phase_cfg #(
    .CNT_W        (CNT_W),
    .DIV_DEFAULT  (DIV_DEFAULT),
    .HIGH_DEFAULT (HIGH_DEFAULT)
  ) u_cfg (
    .clk           (clk),
    .rst           (rst),
    .cfg_load_i    (cfg_load),
    .div_ratio_i   (div_ratio),
    .high_cycles_i (high_cycles),
    .apply_en_i    (applyEn),
    .div_act_o     (divAct),
    .high_act_o    (highAct),
    .cfg_ack_o     (cfg_ack)
  );

  // Next-state logic. Outputs are computed from the next counter value so
  // that clk_slow and the strobes are registered and line up with cnt.
  // Leaving RUN abandons the partial period and clears every output.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clkSlow_d = clkSlow_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    phase_d   = phase_q;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        clkSlow_d = 1'b0;
        phase_d   = '0;
        if (run) begin
          state_d   = S_RUN;
          clkSlow_d = 1'b1;
          rise_d    = 1'b1;
        end
      end
      default: begin
        if (!run) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          clkSlow_d = 1'b0;
          phase_d   = '0;
        end else if (!stallIn) begin
          cnt_d     = cntNext;
          clkSlow_d = (cntNext < highAct);
          rise_d    = (cntNext == '0);
          fall_d    = (cntNext == highAct);
          if (cntNext == '0) begin
            phase_d = (phase_q == PH_W'(NUM_PHASES - 1)) ? '0 : phase_q + PH_W'(1);
          end
        end
      end
    endcase
  end

  // State registers; reset drops back to idle with every output low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      clkSlow_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      phase_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clkSlow_q <= clkSlow_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      phase_q   <= phase_d;
    end
  end

  assign clk_slow  = clkSlow_q;
  assign slow_rise = rise_q;
  assign slow_fall = fall_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// ---------------------------------------------------------------------------
// tb_clock_phase_gen
//
// Directed bench for clock_phase_gen with default parameters (div 4,
// high 2, four phases). Inputs change 1 ns after a rising edge and the
// outputs are examined at that point, i.e. they show the result of the
// edge just taken. With CLOCK_PHASE_GEN_STALL_EN defined the stall port
// is connected and a stall sequence is added.
// ---------------------------------------------------------------------------
module tb_clock_phase_gen;

  logic       clk;
  logic       rst;
  logic       run;
  logic       stall;
  logic       cfgLoad;
  logic [7:0] divRatio;
  logic [7:0] highCycles;
  logic       cfgAck;
  logic       clkSlow;
  logic       slowRise;
  logic       slowFall;
  logic [1:0] phase;

  int assertCount = 0;
  int failCount   = 0;

  clock_phase_gen dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
`ifdef CLOCK_PHASE_GEN_STALL_EN
    .stall       (stall),
`endif
    .cfg_load    (cfgLoad),
    .div_ratio   (divRatio),
    .high_cycles (highCycles),
    .cfg_ack     (cfgAck),
    .clk_slow    (clkSlow),
    .slow_rise   (slowRise),
    .slow_fall   (slowFall),
    .phase       (phase)
  );

  // Free-running 100 MHz system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the functional inputs for the next edge.
  task automatic applyStimulus(input logic runIn, input logic loadIn,
                               input logic [7:0] divIn, input logic [7:0] highIn);
    run        = runIn;
    cfgLoad    = loadIn;
    divRatio   = divIn;
    highCycles = highIn;
  endtask

  // Compare all outputs against the hand-computed expectation in one go.
  task automatic checkOutput(input string tag, input logic eClk, input logic eRise,
                             input logic eFall, input logic [1:0] ePhase,
                             input logic eAck);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {cfgAck, clkSlow, slowRise, slowFall, phase};
    exp = {eAck, eClk, eRise, eFall, ePhase};
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed ack/clk/rise/fall/phase=%b expected %b", tag, obs, exp);
    end
  endtask

  // Take one rising edge, then look at the outputs it produced.
  task automatic stepCheck(input string tag, input logic eClk, input logic eRise,
                           input logic eFall, input logic [1:0] ePhase,
                           input logic eAck);
    @(posedge clk);
    #1;
    checkOutput(tag, eClk, eRise, eFall, ePhase, eAck);
  endtask

  // Reference pattern for the reset-default 4-cycle period.
  logic defClk[4];
  logic defRise[4];
  logic defFall[4];

  initial begin
    defClk  = '{1'b1, 1'b1, 1'b0, 1'b0};
    defRise = '{1'b1, 1'b0, 1'b0, 1'b0};
    defFall = '{1'b0, 1'b0, 1'b1, 1'b0};

    stall = 1'b0;
    rst   = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
    @(posedge clk);
    stepCheck("reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    // Default pattern over five periods: phase 0,1,2,3,0.
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 4; c++) begin
        stepCheck($sformatf("default p%0d c%0d", p, c),
                  defClk[c], defRise[c], defFall[c], 2'(p % 4), 1'b0);
      end
    end

    // Reconfigure to div 6 / high 1 while cnt is 1.
    stepCheck("reconf c0", 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    stepCheck("reconf c1", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'd6, 8'd1);
    stepCheck("reconf c2", 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
    stepCheck("reconf c3", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    stepCheck("reconf ack", 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
    stepCheck("div6 c1", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    for (int c = 2; c < 6; c++) begin
      stepCheck($sformatf("div6 c%0d", c), 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
    end
    stepCheck("div6 wrap", 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
    stepCheck("div6 n1", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    stepCheck("div6 n2", 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);

    // Stop at cnt 2: everything clears next cycle.
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
    stepCheck("stop", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    // Clamp in idle: div 0 / high 9 becomes div 2 / high 1.
    applyStimulus(1'b0, 1'b1, 8'd0, 8'd9);
    stepCheck("clamp load", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
    stepCheck("clamp ack", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
    stepCheck("div2 start", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    stepCheck("div2 low0", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    stepCheck("div2 high1", 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    stepCheck("div2 low1", 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    stepCheck("div2 high2", 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);

    // Load A (5/4) off-boundary, then B (7/3) on the apply edge.
    applyStimulus(1'b1, 1'b1, 8'd5, 8'd4);
    stepCheck("loadA", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'd7, 8'd3);
    stepCheck("applyA", 1'b1, 1'b1, 1'b0, 2'd3, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
    stepCheck("div5 c1", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
    stepCheck("div5 c2", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
    stepCheck("div5 c3", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
    stepCheck("div5 c4", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    stepCheck("applyB", 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);

    // Two loads (9/5 then 3/2) inside one div-7 period: only the last wins.
    applyStimulus(1'b1, 1'b1, 8'd9, 8'd5);
    stepCheck("div7 c1", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'd3, 8'd2);
    stepCheck("div7 c2", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
    stepCheck("div7 c3", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int c = 4; c < 7; c++) begin
      stepCheck($sformatf("div7 c%0d", c), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    end
    stepCheck("applyD", 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
    stepCheck("div3 c1", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    stepCheck("div3 c2", 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    stepCheck("div3 wrap noack", 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    stepCheck("div3 n1", 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);

    // Reset with a pending config: no ack afterwards, defaults restored.
    applyStimulus(1'b1, 1'b1, 8'd10, 8'd5);
    stepCheck("pend before rst", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
    stepCheck("rst mid", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    stepCheck("rst no ack", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
    for (int c = 0; c < 4; c++) begin
      stepCheck($sformatf("post rst c%0d", c), defClk[c], defRise[c], defFall[c], 2'd0, 1'b0);
    end

`ifdef CLOCK_PHASE_GEN_STALL_EN
    // Stall three cycles at cnt 1: a 4+3 cycle period.
    stepCheck("stall c0", 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    stepCheck("stall c1", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      stepCheck($sformatf("stall hold%0d", s), 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    end
    stall = 1'b0;
    stepCheck("stall c2", 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    stepCheck("stall c3", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    stepCheck("stall wrap", 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
